// File: rtl/cpu_pkg.sv
// Shared execute-stage constants and the multiplier FSM state type.
// UMULH_EN widens the multiplier accumulator to the full 2*DATA_WIDTH product.
package cpu_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = ADDR_WIDTH'(31);

`ifdef UMULH_EN
  localparam int unsigned ACC_WIDTH = 2 * DATA_WIDTH;
`else
  localparam int unsigned ACC_WIDTH = DATA_WIDTH;
`endif

  localparam int unsigned COUNT_WIDTH = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_step.sv
// One shift-add multiply iteration: conditional accumulate, then shift the
// multiplicand left and the multiplier right.
module mul_step
  import cpu_pkg::*;
#(
  parameter int unsigned AccWidth = ACC_WIDTH
) (
  input  logic [AccWidth-1:0]   acc_i,
  input  logic [AccWidth-1:0]   mcand_i,
  input  logic [DATA_WIDTH-1:0] mpr_i,
  output logic [AccWidth-1:0]   acc_o,
  output logic [AccWidth-1:0]   mcand_o,
  output logic [DATA_WIDTH-1:0] mpr_o
);

  always_comb begin
    acc_o   = mpr_i[0] ? (acc_i + mcand_i) : acc_i;
    mcand_o = mcand_i << 1;
    mpr_o   = mpr_i >> 1;
  end

endmodule

// File: rtl/mul_iter_unit.sv
// Iterative 64-bit shift-add multiplier feeding the register file write port.
// Build with UMULH_EN to allow selecting the high half of the product via hiSel.
module mul_iter_unit
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] opA,
  input  logic [DATA_WIDTH-1:0] opB,
  input  logic [ADDR_WIDTH-1:0] dstAddr,
  input  logic                  hiSel,
  input  logic                  wrGrant,
  output logic                  ready,
  output logic                  write,
  output logic [ADDR_WIDTH-1:0] wrAddr,
  output logic [DATA_WIDTH-1:0] wrData,
  output logic                  done
);

  mul_state_t                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]       count_q, count_d;
  logic [ACC_WIDTH-1:0]         acc_q, acc_d;
  logic [ACC_WIDTH-1:0]         mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0]        mpr_q, mpr_d;
  logic [ADDR_WIDTH-1:0]        dst_q, dst_d;
  logic [ADDR_WIDTH-1:0]        wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]        wr_data_q, wr_data_d;
  logic                         done_q, done_d;
  logic                         hi_q, hi_d;

  logic [ACC_WIDTH-1:0]         acc_step;
  logic [ACC_WIDTH-1:0]         mcand_step;
  logic [DATA_WIDTH-1:0]        mpr_step;
  logic [DATA_WIDTH-1:0]        result;

  mul_step #(
    .AccWidth (ACC_WIDTH)
  ) u_mul_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .mpr_i   (mpr_q),
    .acc_o   (acc_step),
    .mcand_o (mcand_step),
    .mpr_o   (mpr_step)
  );

`ifdef UMULH_EN
  assign hi_d   = (state_q == IDLE && start) ? hiSel : hi_q;
  assign result = hi_q ? acc_step[ACC_WIDTH-1:DATA_WIDTH] : acc_step[DATA_WIDTH-1:0];
`else
  logic unused_hi_sel;
  assign unused_hi_sel = hiSel;
  assign hi_d          = 1'b0;
  assign result        = acc_step;
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mpr_d     = mpr_q;
    dst_d     = dst_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          count_d = '0;
          acc_d   = '0;
          mcand_d = ACC_WIDTH'(opA);
          mpr_d   = opB;
          dst_d   = dstAddr;
        end
      end
      RUN: begin
        acc_d   = acc_step;
        mcand_d = mcand_step;
        mpr_d   = mpr_step;
        count_d = count_q + 1'b1;
        // Fixed iteration count, no early exit, so latency never depends on data.
        if (count_q == COUNT_WIDTH'(DATA_WIDTH - 1)) begin
          if (dst_q == ZERO_REG) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d   = WB;
            wr_addr_d = dst_q;
            wr_data_d = result;
          end
        end
      end
      WB: begin
        if (wrGrant) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mpr_q     <= '0;
      dst_q     <= '0;
      hi_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mpr_q     <= mpr_d;
      dst_q     <= dst_d;
      hi_q      <= hi_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign ready  = (state_q == IDLE);
  assign write  = (state_q == WB);
  assign wrAddr = wr_addr_q;
  assign wrData = wr_data_q;
  assign done   = done_q;

endmodule
